// File: rtl/crg_pkg.sv
// Shared constants for the clock/reset generator.
// Default channel geometry and reset synchroniser depth.
package crg_pkg;

    localparam int M_DEF       = 4;
    localparam int N_DEF       = 8;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/crg_channel.sv
// One clock/reset channel: reset synchroniser, M glitch-free
// enable chains on the falling edge of each source, and an OR tree.
module crg_channel
    import crg_pkg::*;
#(
    parameter  int M  = M_DEF,
    localparam int SW = $clog2(M)
) (
    input  logic          ref_clk_i,
    input  logic          glob_arst_ni,
    input  logic [M-1:0]  pll_i,
    input  logic [SW-1:0] sel_i,
    input  logic          arst_req_i,
    input  logic          en_i,
    output logic          clk_o,
    output logic          arst_no
);

    logic                   rst_n;
    logic [SYNC_STAGES-1:0] sync_q;

    assign rst_n = glob_arst_ni & ~arst_req_i;

    always_ff @(posedge ref_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign arst_no = sync_q[SYNC_STAGES-1];

    logic [M-1:0] s1;
    logic [M-1:0] s2;
    logic [M-1:0] busy;
    logic [M-1:0] req;

    assign busy = s1 | s2;

    // A source may only start once every other chain is fully drained,
    // so at most one chain per channel is ever live.
    for (genvar i = 0; i < M; i++) begin : g_chain
        localparam logic [M-1:0] OWN = M'(1) << i;

        logic q1;
        logic q2;

        assign req[i] = (sel_i == SW'(i)) & en_i
                      & ~|(busy & ~OWN);

        always_ff @(negedge pll_i[i] or negedge arst_no) begin
            if (!arst_no) begin
                q1 <= 1'b0;
                q2 <= 1'b0;
            end else begin
                q1 <= req[i];
                q2 <= q1;
            end
        end

        assign s1[i] = q1;
        assign s2[i] = q2;
    end

    assign clk_o = |(pll_i & s2);

endmodule

// File: rtl/crg_clk_rst_gen.sv
// Clock-and-reset generator: N independent channels, each muxing
// and gating one of M PLL clocks with its own synchronised reset.
module crg_clk_rst_gen
    import crg_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int N = N_DEF
) (
    input  logic                        ref_clk_i,
    input  logic                        glob_arst_ni,
    input  logic [M-1:0]                pll_i,
    input  logic [N-1:0][$clog2(M)-1:0] sel_i,
    input  logic [N-1:0]                arst_req_i,
    input  logic [N-1:0]                en_i,
    output logic [N-1:0]                clk_o,
    output logic [N-1:0]                arst_no
);

    for (genvar j = 0; j < N; j++) begin : g_ch
        crg_channel #(
            .M (M)
        ) u_ch (
            .ref_clk_i    (ref_clk_i),
            .glob_arst_ni (glob_arst_ni),
            .pll_i        (pll_i),
            .sel_i        (sel_i[j]),
            .arst_req_i   (arst_req_i[j]),
            .en_i         (en_i[j]),
            .clk_o        (clk_o[j]),
            .arst_no      (arst_no[j])
        );
    end

endmodule

// File: tb/tb_crg_clk_rst_gen.sv
// Self-checking bench for crg_clk_rst_gen with a behavioural model.
`timescale 1ns/1ps
module tb_crg_clk_rst_gen;
    import crg_pkg::*;

    localparam int  M      = M_DEF;
    localparam int  N      = N_DEF;
    localparam real SETTLE = 250.0;

    logic ref_clk = 1'b0;
    logic glob_n  = 1'b0;
    logic p0 = 1'b0, p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;
    logic [M-1:0]        pll;
    logic [N-1:0][1:0]   sel = '0;
    logic [N-1:0]        req = '0;
    logic [N-1:0]        en  = '1;
    logic [N-1:0]        clk_o;
    logic [N-1:0]        arst_no;

    int tests = 0;
    int fails = 0;

    int      cnt[N];
    realtime last_chg[N];
    realtime last_edge[N];
    logic [4:0] snap[N];
    logic [N-1:0] clk_prev = '0;

    assign pll = {p3, p2, p1, p0};

    always #5  ref_clk = ~ref_clk;
    always #25 p0 = ~p0;
    always #10 p1 = ~p1;
    always #6  p2 = ~p2;
    always #1  p3 = ~p3;

    crg_clk_rst_gen #(.M(M), .N(N)) dut (
        .ref_clk_i    (ref_clk),
        .glob_arst_ni (glob_n),
        .pll_i        (pll),
        .sel_i        (sel),
        .arst_req_i   (req),
        .en_i         (en),
        .clk_o        (clk_o),
        .arst_no      (arst_no)
    );

    function automatic logic rst_of(int j);
        return !glob_n || req[j];
    endfunction

    function automatic logic exp_clk(int j);
        if (!en[j] || int'(sel[j]) >= M) return 1'b0;
        return pll[sel[j]];
    endfunction

    task automatic chk(string nm, int j, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s ch%0d t=%0t got %0h want %0h",
                     nm, j, $realtime, act, exp);
        end
    endtask

    initial begin
        for (int j = 0; j < N; j++) begin
            cnt[j]       = 0;
            last_chg[j]  = 0.0;
            last_edge[j] = -1.0e6;
            snap[j]      = 5'h1f;
        end
    end

    // reset model: deassert after SYNC_STAGES ref edges of quiet reset
    always @(posedge ref_clk) begin
        for (int j = 0; j < N; j++) begin
            if (rst_of(j)) cnt[j] = 0;
            else if (cnt[j] < SYNC_STAGES) cnt[j] = cnt[j] + 1;
        end
    end

    always @(glob_n or req or en or sel) begin
        for (int j = 0; j < N; j++) begin
            logic [4:0] cur;
            cur = {rst_of(j), en[j], 1'b0, sel[j]};
            if (rst_of(j)) cnt[j] = 0;
            if (cur !== snap[j]) last_chg[j] = $realtime;
            snap[j] = cur;
        end
    end

    initial begin
        #0.5;
        forever begin
            for (int j = 0; j < N; j++) begin
                logic ea;
                ea = !rst_of(j) && cnt[j] >= SYNC_STAGES;
                chk("arst_no", j, 32'(arst_no[j]), 32'(ea));
                if (rst_of(j))
                    chk("clk_in_rst", j, 32'(clk_o[j]), 32'd0);
                else if ($realtime - last_chg[j] >= SETTLE)
                    chk("clk_track", j, 32'(clk_o[j]), 32'(exp_clk(j)));
            end
            #1;
        end
    end

    always @(clk_o) begin
        for (int j = 0; j < N; j++) begin
            if (clk_o[j] !== clk_prev[j]) begin
                if (!rst_of(j)) begin
                    tests++;
                    if ($realtime - last_edge[j] < 0.9) begin
                        fails++;
                        $display("FAIL glitch ch%0d t=%0t width %0t want >=0.9",
                                 j, $realtime, $realtime - last_edge[j]);
                    end
                end
                last_edge[j] = $realtime;
                clk_prev[j]  = clk_o[j];
            end
        end
    end

    task automatic sync_step();
        @(posedge ref_clk);
        #2.3;
    endtask

    initial begin
        #29;
        chk("rst_arst", -1, 32'(arst_no), 32'h00);
        chk("rst_clk", -1, 32'(clk_o), 32'h00);
        #1 glob_n = 1'b1;
        #10;
        chk("arst_one_edge", -1, 32'(arst_no), 32'h00);
        #10;
        chk("arst_released", -1, 32'(arst_no), 32'hff);
        #250.5;
        chk("boot_src0", -1, 32'(clk_o), 32'({N{p0}}));

        sync_step();
        sel[3] = 2'd3;
        #250;
        chk("sel3_track", 3, 32'(clk_o[3]), 32'(p3));
        chk("sel3_others", -1, 32'(clk_o & 8'hf7), 32'({N{p0}} & 8'hf7));

        sync_step();
        req[5] = 1'b1;
        #0.5;
        chk("req5_arst", 5, 32'(arst_no[5]), 32'd0);
        chk("req5_clk", 5, 32'(clk_o[5]), 32'd0);
        sync_step();
        sync_step();
        req[5] = 1'b0;
        #12;
        chk("req5_one_edge", 5, 32'(arst_no[5]), 32'd0);
        #8;
        chk("req5_release", 5, 32'(arst_no[5]), 32'd1);
        #250;
        chk("req5_resume", 5, 32'(clk_o[5]), 32'(p0));

        sync_step();
        sel[2] = 2'd1;
        #250;
        chk("en2_src1", 2, 32'(clk_o[2]), 32'(p1));
        en[2] = 1'b0;
        #60;
        for (int k = 0; k < 20; k++) begin
            chk("en2_off", 2, 32'(clk_o[2]), 32'd0);
            #1;
        end
        en[2] = 1'b1;
        #250;
        chk("en2_on", 2, 32'(clk_o[2]), 32'(p1));

        for (int it = 0; it < 100; it++) begin
            sync_step();
            for (int j = 0; j < N; j++) begin
                if ($urandom_range(99) < 30) begin
                    sel[j] = 2'($urandom_range(3));
                    en[j]  = $urandom_range(99) < 85;
                    req[j] = $urandom_range(99) < 15;
                end
            end
            if ($urandom_range(99) < 10) begin
                #3;
                sel[$urandom_range(N - 1)] = 2'($urandom_range(3));
            end
            if ($urandom_range(99) < 3) begin
                glob_n = 1'b0;
                #(10 * (2 + $urandom_range(2)));
                glob_n = 1'b1;
            end
            repeat (8) @(posedge ref_clk);
        end

        sync_step();
        req    = '0;
        en     = '1;
        #300;
        chk("final_arst", -1, 32'(arst_no), 32'hff);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
